// File: rtl/counter_dflipflop_sync_up_4bit.sv
// counter_dflipflop_sync_up_4bit: synchronous 4-bit up counter, terminal count MAXVAL, sticky wrap flag
// Optional parallel load compiled in with `define COUNTER_SYNC_UP_LOAD_EN
module counter_dflipflop_sync_up_4bit #(
  parameter int unsigned MAXVAL = 15
) (
  input  logic       Clk,
  input  logic       ClrN,
  input  logic       En,
  input  logic       Load,
  input  logic [3:0] D,
  output logic [3:0] count,
  output logic       Tc,
  output logic       Ovf
);
  localparam logic [3:0] MAX = 4'(MAXVAL);
  logic [3:0] r_count;
  logic       r_ovf;
  logic       w_top;
  assign w_top = r_count >= MAX;
  assign Tc    = En & w_top;
  assign count = r_count;
  assign Ovf   = r_ovf;
`ifndef COUNTER_SYNC_UP_LOAD_EN
  logic w_unused;
  assign w_unused = ^{Load, D};
`endif
  always_ff @(posedge Clk) begin
    if (!ClrN) begin
      r_count <= 4'd0;
      r_ovf   <= 1'b0;
`ifdef COUNTER_SYNC_UP_LOAD_EN
    end else if (Load) begin
      r_count <= D;
      r_ovf   <= 1'b0;
`endif
    end else if (En) begin
      r_count <= w_top ? 4'd0 : r_count + 4'd1;
      r_ovf   <= r_ovf | w_top;
    end
  end
endmodule

// File: tb/tb_counter_dflipflop_sync_up_4bit.sv
// tb_counter_dflipflop_sync_up_4bit: directed checks of MAXVAL=15 and MAXVAL=9 counters sharing stimulus
module tb_counter_dflipflop_sync_up_4bit;
  logic       Clk = 0, ClrN = 0, En = 0, Load = 0;
  logic [3:0] D = 0;
  logic [3:0] c15, c9;
  logic       tc15, tc9, ovf15, ovf9;
  int n_vec = 0, n_err = 0;

  counter_dflipflop_sync_up_4bit #(.MAXVAL(15)) u15 (
    .Clk(Clk), .ClrN(ClrN), .En(En), .Load(Load), .D(D),
    .count(c15), .Tc(tc15), .Ovf(ovf15));
  counter_dflipflop_sync_up_4bit #(.MAXVAL(9)) u9 (
    .Clk(Clk), .ClrN(ClrN), .En(En), .Load(Load), .D(D),
    .count(c9), .Tc(tc9), .Ovf(ovf9));

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    ClrN = 0;
    tick();
    ClrN = 1;
  endtask

  task automatic run(input int n);
    En = 1;
    repeat (n) tick();
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_c15", c15, 0);
    check("rst_ovf15", ovf15, 0);
    check("rst_c9", c9, 0);
    check("rst_ovf9", ovf9, 0);
    check("rst_tc15", tc15, 0);
    // free count on both moduli
    En = 1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      check("free_c15", c15, i % 16);
      check("free_ovf15", ovf15, int'(i >= 16));
      check("free_tc15", tc15, int'(i % 16 == 15));
      check("mod_c9", c9, i % 10);
      check("mod_ovf9", ovf9, int'(i >= 10));
      check("mod_tc9", tc9, int'(i % 10 == 9));
    end
    // hold at 3
    do_reset();
    run(3);
    En = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_c15", c15, 3);
      check("hold_tc15", tc15, 0);
      check("hold_c9", c9, 3);
    end
    // reset between edges at 7, overriding load and enable
    run(4);
    check("pre_rst_c15", c15, 7);
    #2;
    ClrN = 0; Load = 1; En = 1; D = 4'hA;
    #1;
    check("midrst_hold_c15", c15, 7);
    check("midrst_hold_c9", c9, 7);
    tick();
    check("srst_c15", c15, 0);
    check("srst_ovf15", ovf15, 0);
    check("srst_c9", c9, 0);
    Load = 0; ClrN = 1;
    // Tc during reset follows the registered count
    run(9);
    ClrN = 0;
    #1;
    check("rst_tc9_at9", tc9, 1);
    tick();
    check("rst_tc9_at0", tc9, 0);
    ClrN = 1;
    tick();
    check("resume_c9", c9, 1);
    // load priority at count 5
    do_reset();
    run(5);
    Load = 1; D = 4'hC;
    tick();
`ifdef COUNTER_SYNC_UP_LOAD_EN
    check("load_c15", c15, 12);
    check("load_c9", c9, 12);
    check("load_ovf9", ovf9, 0);
    check("load_tc9", tc9, 1);
    Load = 0;
    tick();
    check("postload_c9", c9, 0);
    check("postload_ovf9", ovf9, 1);
    check("postload_c15", c15, 13);
    check("postload_ovf15", ovf15, 0);
`else
    check("noload_c15", c15, 6);
    check("noload_c9", c9, 6);
    Load = 0;
    tick();
    check("noload_next_c9", c9, 7);
`endif
    // load at count 2 with sticky flag set on the mod-10 counter
    do_reset();
    run(12);
    check("pre_c9", c9, 2);
    check("pre_ovf9", ovf9, 1);
    Load = 1; D = 4'hA;
    tick();
`ifdef COUNTER_SYNC_UP_LOAD_EN
    check("ld2_c9", c9, 10);
    check("ld2_ovf9", ovf9, 0);
    check("ld2_c15", c15, 10);
`else
    check("ign_c9", c9, 3);
    check("ign_ovf9", ovf9, 1);
    check("ign_c15", c15, 13);
    check("ign_ovf15", ovf15, 0);
`endif
    Load = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/counter_dflipflop_sync_up_4bit.md
COUNTER_DFLIPFLOP_SYNC_UP_4BIT -- requirements
Module: counter_dflipflop_sync_up_4bit

Interface
REQ-001 The block SHALL have one parameter: MAXVAL, default 15, terminal count value; the legal range is 1..15.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port ClrN, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port En, input, 1 bit: count enable.
REQ-005 The block SHALL have port Load, input, 1 bit: parallel-load strobe.
REQ-006 The block SHALL have port D, input, 4 bits: parallel-load data.
REQ-007 The block SHALL have port count, output, 4 bits: registered counter value, bit 0 the LSB.
REQ-008 The block SHALL have port Tc, output, 1 bit: combinational terminal-count flag for cascading.
REQ-009 The block SHALL have port Ovf, output, 1 bit: registered sticky wrap flag.

Function
REQ-010 All four count bits SHALL be clocked from Clk with no ripple clocking; count changes only on a rising Clk edge.
REQ-011 Next-state priority SHALL be: ClrN low, then Load high, then En high, then hold.
REQ-012 With ClrN high, Load low, En high and count < MAXVAL, count SHALL increment by 1 at the next edge (latency: 1 cycle).
REQ-013 With ClrN high, Load low, En high and count >= MAXVAL, count SHALL become 0 and Ovf SHALL set to 1 at the same edge.
REQ-014 With ClrN high, Load low and En low, count and Ovf SHALL hold.
REQ-015 When Load is high (ClrN high), count SHALL take D at the next edge regardless of En, and Ovf SHALL clear to 0.
REQ-016 A loaded D value above MAXVAL SHALL be accepted; the next enabled edge SHALL wrap to 0 per REQ-013.
REQ-017 Tc SHALL equal En AND (count >= MAXVAL), combinationally, with no clock delay.
REQ-018 Ovf SHALL remain 1 after being set until reset or Load; further wraps SHALL keep it at 1.
REQ-019 Arithmetic SHALL be 4-bit unsigned; no count value outside 0..15 SHALL be representable.

Reset
REQ-020 When ClrN is sampled low at a rising Clk edge, count SHALL become 0 and Ovf SHALL become 0, overriding Load and En.
REQ-021 Reset SHALL have no effect between clock edges; outputs SHALL hold until the next rising edge.
REQ-022 Reset asserted mid-count SHALL take effect on the same edge, and counting SHALL resume from 0 on the first edge with ClrN high and En high.
REQ-023 While ClrN is low and En is high, Tc SHALL reflect the current registered count per REQ-017.

Configuration
REQ-024 The macro COUNTER_SYNC_UP_LOAD_EN, when defined, SHALL compile in the parallel-load path per REQ-015 and REQ-016.
REQ-025 When COUNTER_SYNC_UP_LOAD_EN is not defined, the Load and D ports SHALL remain present but SHALL be ignored, Ovf SHALL clear only on reset, and all other requirements SHALL be unchanged.

Verification
REQ-026 The bench SHALL cover free count: MAXVAL=15, ClrN=1, En=1 for 17 edges from reset -> count 1,2,...,15,0,1; Ovf goes to 1 at the 16th edge; Tc=1 only while count=15.
REQ-027 The bench SHALL cover modulus: MAXVAL=9, En=1 -> count runs 0..9,0; Tc=1 at count=9; Ovf=1 after the 10th edge.
REQ-028 The bench SHALL cover load priority (macro defined): count=5, Load=1, En=1, D=4'hC -> count=12 and Ovf=0 after 1 edge; with MAXVAL=9 the next enabled edge gives count=0 and Ovf=1.
REQ-029 The bench SHALL cover synchronous reset: count=7, ClrN driven low between edges -> count stays 7 until the next edge, then count=0 and Ovf=0, even with Load=1 and En=1.
REQ-030 The bench SHALL cover hold: En=0 for 5 edges at count=3 -> count=3 throughout and Tc=0.
REQ-031 The bench SHALL cover the macro undefined: Load=1, D=4'hA, En=1 at count=2 -> count=3 and Ovf unchanged.
